// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end: issues word reads to instruction memory and
// buffers the returned {IR, NPC} pairs in a small FIFO for the decode stage.
// Redirects flush the queue and drop any stale in-flight word; halt blocks
// new issues while the queue keeps draining.
module mips32_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk1,
  input  logic                       rst_n,
  output logic                       imem_rd_en,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_ir,
  output logic [31:0]                out_npc,
  output logic [$clog2(DEPTH):0]     queue_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthW = (CW+1)'(DEPTH);

  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   last_ir_q, last_npc_q;

  logic [31:0]   ir_mem  [DEPTH];
  logic [31:0]   npc_mem [DEPTH];

  logic          issue, push, pop;
  logic [CW:0]   occupancy;

  // Issue / push / pop decode; redirect suppresses all three.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue      = rst_n & ~halt & ~redirect_valid & (occupancy < DepthW);
    push       = rst_n & ~redirect_valid & inflight_q;
    pop        = rst_n & ~redirect_valid & out_valid & out_ready;
    imem_rd_en = issue;
    imem_addr  = pc_q[ADDR_W-1:0];
  end

  // Head presentation; holds the last popped entry while the queue is empty.
  always_comb begin
    out_valid   = (count_q != '0);
    queue_count = count_q;
    out_ir      = last_ir_q;
    out_npc     = last_npc_q;
    if (out_valid) begin
      out_ir  = ir_mem[rd_ptr_q];
      out_npc = npc_mem[rd_ptr_q];
    end
  end

  // PC, in-flight tracking, pointers and occupancy.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      last_ir_q     <= '0;
      last_npc_q    <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        last_ir_q  <= ir_mem[rd_ptr_q];
        last_npc_q <= npc_mem[rd_ptr_q];
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage; the issue rule guarantees a free slot on every push.
  always_ff @(posedge clk1) begin
    if (push) begin
      ir_mem[wr_ptr_q]  <= imem_rdata;
      npc_mem[wr_ptr_q] <= inflight_pc_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_mips32_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_rd_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_ir, out_npc;
  logic [2:0]  queue_count;

  int total = 0;
  int bad = 0;

  mips32_fetch_queue #(.DEPTH(4), .ADDR_W(10), .RESET_PC(32'h0)) dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ir         (out_ir),
    .out_npc        (out_npc),
    .queue_count    (queue_count)
  );

  always #5 clk1 = ~clk1;

  // Instruction memory: MEM[i] = 0x1000_0000 + i, one-cycle read latency.
  logic [31:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
  always @(posedge clk1) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  // Reference model: a plain queue of expected entries, a fetch PC and at most
  // one outstanding read.
  typedef struct packed {logic [31:0] ir; logic [31:0] npc;} ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_inf = 0;
  logic [31:0] m_inf_pc = 32'h0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + {22'd0, a[9:0]};
  endfunction

  always @(posedge clk1) begin
    bit issue;
    if (!rst_n) begin
      mq.delete(); m_pc = 32'h0; m_inf = 0;
    end else if (redirect_valid) begin
      mq.delete(); m_pc = redirect_pc; m_inf = 0;
    end else begin
      issue = !halt && (mq.size() + int'(m_inf) < DEPTH);
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (m_inf) mq.push_back({word_at(m_inf_pc), m_inf_pc + 32'd1});
      if (issue) begin
        m_inf = 1; m_inf_pc = m_pc; m_pc = m_pc + 32'd1;
      end else begin
        m_inf = 0;
      end
    end
  end

  task automatic do_reset();
    rst_n = 0; redirect_valid = 0; halt = 0; out_ready = 0;
    repeat (2) @(negedge clk1);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (imem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", imem_rd_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", queue_count); end
    total++; if (imem_addr !== 10'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1; rst_n = 1;
    @(negedge clk1); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_edge1_valid got=%b exp=0", out_valid); end
    @(negedge clk1); #1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_ir !== 32'h1000_0000 + k || out_npc !== k + 1) begin
        bad++;
        $display("FAIL stream_word%0d got v=%b ir=%h npc=%h exp v=1 ir=%h npc=%h",
                 k, out_valid, out_ir, out_npc, 32'h1000_0000 + k, k + 1);
      end
      @(negedge clk1); #1;
    end
  endtask

  task automatic test_backpressure();
    int got = 0;
    do_reset();
    rst_n = 1;
    repeat (8) @(negedge clk1);
    #1;
    total++; if (queue_count !== 3'd4) begin bad++; $display("FAIL bp_full_count got=%0d exp=4", queue_count); end
    for (int c = 0; c < 3; c++) begin
      total++; if (imem_rd_en !== 1'b0) begin bad++; $display("FAIL bp_full_rd_en got=%b exp=0", imem_rd_en); end
      @(negedge clk1); #1;
    end
    out_ready = 1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      #1;
      if (out_valid) begin
        total++;
        if (out_ir !== 32'h1000_0000 + got || out_npc !== got + 1) begin
          bad++; $display("FAIL bp_order%0d got ir=%h npc=%h exp ir=%h npc=%h",
                          got, out_ir, out_npc, 32'h1000_0000 + got, got + 1);
        end
        got++;
      end
      @(negedge clk1);
    end
    total++; if (got != 10) begin bad++; $display("FAIL bp_timeout got=%0d exp=10", got); end
  endtask

  task automatic test_redirect();
    int got = 0;
    do_reset();
    rst_n = 1;
    repeat (4) @(negedge clk1);
    #1;
    total++; if (queue_count !== 3'd3) begin bad++; $display("FAIL redir_pre_count got=%0d exp=3", queue_count); end
    redirect_valid = 1; redirect_pc = 32'h20; out_ready = 1;
    #1;
    total++; if (imem_rd_en !== 1'b0) begin bad++; $display("FAIL redir_rd_en got=%b exp=0", imem_rd_en); end
    @(negedge clk1);
    redirect_valid = 0;
    #1;
    total++; if (queue_count !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL redir_flush got count=%0d v=%b exp count=0 v=0", queue_count, out_valid);
    end
    for (int c = 0; c < 20 && got < 3; c++) begin
      #1;
      if (out_valid) begin
        total++;
        if (out_ir !== 32'h1000_0020 + got || out_npc !== 32'h21 + got) begin
          bad++; $display("FAIL redir_word%0d got ir=%h npc=%h exp ir=%h npc=%h",
                          got, out_ir, out_npc, 32'h1000_0020 + got, 32'h21 + got);
        end
        got++;
      end
      @(negedge clk1);
    end
    total++; if (got != 3) begin bad++; $display("FAIL redir_timeout got=%0d exp=3", got); end
  endtask

  task automatic test_halt();
    int got = 0;
    do_reset();
    out_ready = 1; rst_n = 1;
    repeat (6) @(negedge clk1);
    #1;
    total++; if (out_ir !== 32'h1000_0004 || queue_count !== 3'd1) begin
      bad++; $display("FAIL halt_pre got ir=%h count=%0d exp ir=10000004 count=1", out_ir, queue_count);
    end
    halt = 1; out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (imem_rd_en !== 1'b0) begin bad++; $display("FAIL halt_rd_en got=%b exp=0", imem_rd_en); end
      @(negedge clk1);
    end
    #1;
    total++; if (queue_count !== 3'd2) begin bad++; $display("FAIL halt_inflight_kept got=%0d exp=2", queue_count); end
    out_ready = 1;
    for (int c = 0; c < 10 && got < 2; c++) begin
      #1;
      if (out_valid) begin
        total++;
        if (out_ir !== 32'h1000_0004 + got) begin
          bad++; $display("FAIL halt_drain%0d got=%h exp=%h", got, out_ir, 32'h1000_0004 + got);
        end
        got++;
      end
      @(negedge clk1);
    end
    #1;
    total++; if (queue_count !== 3'd0) begin bad++; $display("FAIL halt_drained got=%0d exp=0", queue_count); end
    halt = 0; got = 0;
    for (int c = 0; c < 10 && got < 1; c++) begin
      #1;
      if (out_valid) begin
        total++;
        if (out_ir !== 32'h1000_0006 || out_npc !== 32'd7) begin
          bad++; $display("FAIL halt_resume got ir=%h npc=%h exp ir=10000006 npc=7", out_ir, out_npc);
        end
        got++;
      end
      @(negedge clk1);
    end
    total++; if (got != 1) begin bad++; $display("FAIL halt_resume_timeout got=%0d exp=1", got); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rst_n = 1;
    repeat (4) @(negedge clk1);
    #1;
    total++; if (queue_count !== 3'd3) begin bad++; $display("FAIL rmid_pre got=%0d exp=3", queue_count); end
    rst_n = 0;
    @(negedge clk1); #1;
    total++; if (out_valid !== 1'b0 || queue_count !== 3'd0 || imem_addr !== 10'd0) begin
      bad++; $display("FAIL rmid_post got v=%b count=%0d addr=%h exp v=0 count=0 addr=0",
                      out_valid, queue_count, imem_addr);
    end
    rst_n = 1;
  endtask

  task automatic test_addr_wrap();
    int got = 0;
    do_reset();
    out_ready = 1; rst_n = 1;
    repeat (3) @(negedge clk1);
    redirect_valid = 1; redirect_pc = 32'h3FF;
    @(negedge clk1);
    redirect_valid = 0;
    #1;
    total++; if (imem_addr !== 10'h3FF || imem_rd_en !== 1'b1) begin
      bad++; $display("FAIL wrap_addr0 got addr=%h en=%b exp addr=3ff en=1", imem_addr, imem_rd_en);
    end
    @(negedge clk1); #1;
    total++; if (imem_addr !== 10'h000) begin bad++; $display("FAIL wrap_addr1 got=%h exp=000", imem_addr); end
    for (int c = 0; c < 10 && got < 2; c++) begin
      #1;
      if (out_valid) begin
        total++;
        if (out_npc !== 32'h400 + got || out_ir !== (got == 0 ? 32'h1000_03FF : 32'h1000_0000)) begin
          bad++; $display("FAIL wrap_word%0d got ir=%h npc=%h exp npc=%h", got, out_ir, out_npc, 32'h400 + got);
        end
        got++;
      end
      @(negedge clk1);
    end
    total++; if (got != 2) begin bad++; $display("FAIL wrap_timeout got=%0d exp=2", got); end
  endtask

  task automatic test_random();
    bit   exp_en;
    ent_t h;
    do_reset();
    rst_n = 1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk1);
      rst_n          = ($urandom_range(0, 99) != 0);
      redirect_valid = ($urandom_range(0, 99) < 5);
      redirect_pc    = $urandom;
      halt           = ($urandom_range(0, 99) < 15);
      out_ready      = ($urandom_range(0, 99) < 60);
      #1;
      exp_en = rst_n && !halt && !redirect_valid && (mq.size() + int'(m_inf) < DEPTH);
      total++;
      if (imem_rd_en !== exp_en || imem_addr !== m_pc[9:0] ||
          out_valid !== (mq.size() != 0) || queue_count !== 3'(mq.size())) begin
        bad++;
        $display("FAIL rand_ctl cyc=%0d got en=%b addr=%h v=%b cnt=%0d exp en=%b addr=%h v=%b cnt=%0d",
                 c, imem_rd_en, imem_addr, out_valid, queue_count, exp_en, m_pc[9:0],
                 mq.size() != 0, mq.size());
      end
      if (mq.size() != 0) begin
        h = mq[0];
        total++;
        if (out_ir !== h.ir || out_npc !== h.npc) begin
          bad++; $display("FAIL rand_head cyc=%0d got ir=%h npc=%h exp ir=%h npc=%h",
                          c, out_ir, out_npc, h.ir, h.npc);
        end
      end
    end
    redirect_valid = 0; halt = 0; rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_addr_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
